// File: rtl/add_share_arbiter.sv
// Shares one registered 8-bit adder between requesters A and B: arbitrate, issue, wait ADD_LAT, return sum.
// Optional build macro ADDER_ARB_FIXED_PRIO_EN selects fixed priority (A wins ties) instead of round-robin.
module add_share_arbiter #(
  parameter int ADD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] a_op0,
  input  logic [7:0] a_op1,
  input  logic       req_b,
  input  logic [7:0] b_op0,
  input  logic [7:0] b_op1,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy,
  output logic       add_en,
  output logic [7:0] add_op0,
  output logic [7:0] add_op1,
  input  logic [7:0] add_sum
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ADD_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic       owner;
  logic [3:0] cnt;
  logic       req_any;
  logic       winner;

  assign req_any = req_a | req_b;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  assign winner = ~req_a;
`else
  logic last_id;

  // On a tie the requester that did not win last time goes next.
  assign winner = (req_a && req_b) ? ~last_id : req_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= 1'b1;
    end else if (state == IDLE && req_any) begin
      last_id <= winner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands stay latched after the transaction so the adder inputs never glitch mid-flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= 1'b0;
      cnt      <= 4'd0;
      add_op0  <= 8'd0;
      add_op1  <= 8'd0;
      rsp_data <= 8'd0;
      rsp_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            owner   <= winner;
            add_op0 <= winner ? b_op0 : a_op0;
            add_op1 <= winner ? b_op1 : a_op1;
          end
        end
        ISSUE: cnt <= CNT_INIT;
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data <= add_sum;
            rsp_id   <= owner;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign add_en = (state == ISSUE);
  assign gnt_a  = busy & ~owner;
  assign gnt_b  = busy & owner;
  assign done_a = (state == DONE) & ~owner;
  assign done_b = (state == DONE) & owner;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed self-checking bench: one arbiter with ADD_LAT=1 and one with ADD_LAT=3, each with a registered adder stub.
module tb_add_share_arbiter;

  logic       clk;
  logic       rst;

  logic       req_a, req_b;
  logic [7:0] a_op0, a_op1, b_op0, b_op1;
  logic       gnt_a, gnt_b, done_a, done_b, rsp_id, busy, add_en;
  logic [7:0] rsp_data, add_op0, add_op1, add_sum;

  logic       req_a2, req_b2;
  logic [7:0] a2_op0, a2_op1, b2_op0, b2_op1;
  logic       gnt_a2, gnt_b2, done_a2, done_b2, rsp_id2, busy2, add_en2;
  logic [7:0] rsp_data2, add_op0_2, add_op1_2, add_sum2;
  logic [7:0] pipe1, pipe2;

  int n_cmp;
  int n_fail;

  add_share_arbiter #(.ADD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a_op0(a_op0), .a_op1(a_op1),
    .req_b(req_b), .b_op0(b_op0), .b_op1(b_op1),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
    .add_en(add_en), .add_op0(add_op0), .add_op1(add_op1), .add_sum(add_sum)
  );

  add_share_arbiter #(.ADD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_a(req_a2), .a_op0(a2_op0), .a_op1(a2_op1),
    .req_b(req_b2), .b_op0(b2_op0), .b_op1(b2_op1),
    .gnt_a(gnt_a2), .gnt_b(gnt_b2), .done_a(done_a2), .done_b(done_b2),
    .rsp_data(rsp_data2), .rsp_id(rsp_id2), .busy(busy2),
    .add_en(add_en2), .add_op0(add_op0_2), .add_op1(add_op1_2), .add_sum(add_sum2)
  );

  // Adder stubs produce 0xEE when no add was issued, so a mistimed sample is visible.
  always_ff @(posedge clk) begin
    add_sum  <= add_en ? add_op0 + add_op1 : 8'hEE;
    pipe1    <= add_en2 ? add_op0_2 + add_op1_2 : 8'hEE;
    pipe2    <= pipe1;
    add_sum2 <= pipe2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({gnt_a, gnt_b, done_a, done_b, add_en, busy, rsp_id} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctl: got %b expected 0000000", {gnt_a, gnt_b, done_a, done_b, add_en, busy, rsp_id});
    end
    n_cmp++;
    if ({add_op0, add_op1, rsp_data} !== 24'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h expected 000000", {add_op0, add_op1, rsp_data});
    end
    n_cmp++;
    if ({gnt_a2, gnt_b2, done_a2, done_b2, add_en2, busy2, rsp_id2, add_op0_2, add_op1_2, rsp_data2} !== 31'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_lat3: got %h expected 0",
               {gnt_a2, gnt_b2, done_a2, done_b2, add_en2, busy2, rsp_id2, add_op0_2, add_op1_2, rsp_data2});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_a();
    req_a = 1'b1; a_op0 = 8'h12; a_op1 = 8'h34;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_a_c0_busy: got %b expected 0", busy);
    end
    step();
    n_cmp++;
    if ({add_en, gnt_a, gnt_b, busy} !== 4'b1101) begin
      n_fail++;
      $display("[TB] FAIL single_a_c1_ctl: got %b expected 1101", {add_en, gnt_a, gnt_b, busy});
    end
    n_cmp++;
    if ({add_op0, add_op1} !== 16'h1234) begin
      n_fail++;
      $display("[TB] FAIL single_a_c1_ops: got %h expected 1234", {add_op0, add_op1});
    end
    step();
    n_cmp++;
    if ({add_en, gnt_a, busy, done_a} !== 4'b0110) begin
      n_fail++;
      $display("[TB] FAIL single_a_c2_ctl: got %b expected 0110", {add_en, gnt_a, busy, done_a});
    end
    step();
    n_cmp++;
    if ({done_a, done_b, rsp_id} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL single_a_c3_done: got %b expected 100", {done_a, done_b, rsp_id});
    end
    n_cmp++;
    if (rsp_data !== 8'h46) begin
      n_fail++;
      $display("[TB] FAIL single_a_c3_data: got %h expected 46", rsp_data);
    end
    req_a = 1'b0;
    step();
    n_cmp++;
    if ({busy, gnt_a, done_a} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL single_a_c4_idle: got %b expected 000", {busy, gnt_a, done_a});
    end
    n_cmp++;
    if (rsp_data !== 8'h46) begin
      n_fail++;
      $display("[TB] FAIL single_a_c4_hold: got %h expected 46", rsp_data);
    end
  endtask

  task automatic test_wrap_b();
    logic saw_gnt_a;
    saw_gnt_a = 1'b0;
    req_b = 1'b1; b_op0 = 8'hF0; b_op1 = 8'h20;
    step();
    saw_gnt_a |= gnt_a;
    n_cmp++;
    if ({add_en, gnt_b} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL wrap_b_c1_ctl: got %b expected 11", {add_en, gnt_b});
    end
    step();
    saw_gnt_a |= gnt_a;
    step();
    saw_gnt_a |= gnt_a;
    n_cmp++;
    if ({done_a, done_b, rsp_id} !== 3'b011) begin
      n_fail++;
      $display("[TB] FAIL wrap_b_c3_done: got %b expected 011", {done_a, done_b, rsp_id});
    end
    n_cmp++;
    if (rsp_data !== 8'h10) begin
      n_fail++;
      $display("[TB] FAIL wrap_b_c3_data: got %h expected 10", rsp_data);
    end
    req_b = 1'b0;
    step();
    saw_gnt_a |= gnt_a;
    n_cmp++;
    if ({saw_gnt_a, busy} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL wrap_b_gnt_a_busy: got %b expected 00", {saw_gnt_a, busy});
    end
  endtask

  // Both held; req_a is dropped at the third completion so each build ends with a B transaction.
  task automatic test_back_to_back();
    logic [3:0] exp_ids;
    logic [1:0] exp_done;
    int k;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    exp_ids = 4'b1000;
`else
    exp_ids = 4'b1010;
`endif
    k = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 1'b1; a_op0 = 8'h10; a_op1 = 8'h01;
    req_b = 1'b1; b_op0 = 8'h20; b_op1 = 8'h02;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c % 4 == 3) begin
        exp_done = exp_ids[k] ? 2'b01 : 2'b10;
        n_cmp++;
        if ({done_a, done_b, rsp_id} !== {exp_done, exp_ids[k]}) begin
          n_fail++;
          $display("[TB] FAIL b2b_done_%0d: got %b expected %b", k, {done_a, done_b, rsp_id}, {exp_done, exp_ids[k]});
        end
        n_cmp++;
        if (rsp_data !== (exp_ids[k] ? 8'h22 : 8'h11)) begin
          n_fail++;
          $display("[TB] FAIL b2b_data_%0d: got %h expected %h", k, rsp_data, exp_ids[k] ? 8'h22 : 8'h11);
        end
        if (k == 2) req_a = 1'b0;
        if (k == 3) req_b = 1'b0;
        k++;
      end else begin
        n_cmp++;
        if ({done_a, done_b, gnt_a & gnt_b} !== 3'b000) begin
          n_fail++;
          $display("[TB] FAIL b2b_quiet_c%0d: got %b expected 000", c, {done_a, done_b, gnt_a & gnt_b});
        end
      end
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_end_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    req_a = 1'b1; a_op0 = 8'h55; a_op1 = 8'h11;
    step();
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({gnt_a, gnt_b, done_a, done_b, add_en, busy, rsp_id} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_ctl: got %b expected 0000000", {gnt_a, gnt_b, done_a, done_b, add_en, busy, rsp_id});
    end
    n_cmp++;
    if ({add_op0, add_op1, rsp_data} !== 24'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_data: got %h expected 000000", {add_op0, add_op1, rsp_data});
    end
    rst = 1'b0;
    req_b = 1'b1; b_op0 = 8'h66; b_op1 = 8'h22;
    step();
    n_cmp++;
    if ({gnt_a, gnt_b, add_en, add_op0, add_op1} !== {3'b101, 16'h5511}) begin
      n_fail++;
      $display("[TB] FAIL midreset_regrant: got %h expected %h", {gnt_a, gnt_b, add_en, add_op0, add_op1}, {3'b101, 16'h5511});
    end
    step();
    step();
    n_cmp++;
    if ({done_a, done_b, rsp_id, rsp_data} !== {3'b100, 8'h66}) begin
      n_fail++;
      $display("[TB] FAIL midreset_done: got %h expected %h", {done_a, done_b, rsp_id, rsp_data}, {3'b100, 8'h66});
    end
    req_a = 1'b0;
    req_b = 1'b0;
    step();
  endtask

  task automatic test_latency3();
    req_a2 = 1'b1; a2_op0 = 8'h01; a2_op1 = 8'hFF;
    step();
    n_cmp++;
    if ({add_en2, gnt_a2, busy2} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL lat3_c1_issue: got %b expected 111", {add_en2, gnt_a2, busy2});
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      n_cmp++;
      if ({add_en2, done_a2, busy2} !== 3'b001) begin
        n_fail++;
        $display("[TB] FAIL lat3_c%0d_wait: got %b expected 001", c, {add_en2, done_a2, busy2});
      end
    end
    step();
    n_cmp++;
    if ({done_a2, done_b2, rsp_id2, rsp_data2} !== {3'b100, 8'h00}) begin
      n_fail++;
      $display("[TB] FAIL lat3_c5_done: got %h expected %h", {done_a2, done_b2, rsp_id2, rsp_data2}, {3'b100, 8'h00});
    end
    req_a2 = 1'b0;
    step();
    n_cmp++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lat3_c6_idle: got %b expected 0", busy2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    a_op0 = 8'h00; a_op1 = 8'h00; b_op0 = 8'h00; b_op1 = 8'h00;
    req_a2 = 1'b0; req_b2 = 1'b0;
    a2_op0 = 8'h00; a2_op1 = 8'h00; b2_op0 = 8'h00; b2_op1 = 8'h00;
    $display("[TB] start");
    test_reset();
    test_single_a();
    test_wrap_b();
    test_back_to_back();
    test_reset_mid_wait();
    test_latency3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
